// File: rtl/seq_sub64_if.sv
// rtl/seq_sub64_if.sv - operand/result handshake bundle for the sliced subtractor
interface seq_sub64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/seq_sub64.sv
// rtl/seq_sub64.sv - multi-cycle subtractor, one CHUNK-bit slice per clock with rippled borrow
module seq_sub64 #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input logic        clk,
    input logic        rst_n,
    seq_sub64_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             out_valid_q;

    int               base;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sub;
    logic [CHUNK-1:0] d_slice;
    logic             br;
    logic             last_slice;

    // One CHUNK+1 bit subtract per cycle; the top bit is the borrow into the next slice.
    always_comb begin
        base       = int'(idx) * CHUNK;
        a_slice    = a_q[base +: CHUNK];
        b_slice    = b_q[base +: CHUNK];
        slice_sub  = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow};
        d_slice    = slice_sub[CHUNK-1:0];
        br         = slice_sub[CHUNK];
        last_slice = (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            borrow      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        borrow <= bus.bin;
                        idx    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    diff_q[base +: CHUNK] <= d_slice;
                    borrow                <= br;
                    idx                   <= idx + 1'b1;
                    if (last_slice) begin
                        // d_slice holds the final diff MSB, so overflow is decided here.
                        idx         <= '0;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        bout_q      <= br;
                        ovf_q       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                       (a_q[WIDTH-1] ^ d_slice[CHUNK-1]);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_sub64.sv
// tb/tb_seq_sub64.sv - randomized and directed bench for seq_sub64 against an arithmetic model
module tb_seq_sub64;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_sub64_if #(.WIDTH(64)) bus ();

    seq_sub64 #(.WIDTH(64), .CHUNK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide arithmetic, signed overflow as an out-of-range test.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic bin,
                                  output logic [63:0] d, output logic bo, output logic ov);
        logic signed [65:0] s;
        d  = a - b - 64'(bin);
        bo = ({1'b0, a} < ({1'b0, b} + 65'(bin)));
        s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bin});
        ov = (s > $signed({3'b000, {63{1'b1}}})) || (s < $signed({3'b111, 63'd0}));
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = {64{1'b1}};
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            4:       v = 64'($urandom_range(0, 3));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Drives one operation and reports what came back; ok = 0 on a timeout.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                          input int hold, output logic [63:0] d, output logic bo,
                          output logic ov, output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        d   = '0;
        bo  = 1'b0;
        ov  = 1'b0;
        n   = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0;
            return;
        end
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.bin      = 1'($urandom_range(0, 1));
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) begin
            ok = 1'b0;
            return;
        end
        d  = bus.diff;
        bo = bus.bout;
        ov = bus.ovf;
        repeat (hold) tick();
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.diff !== 64'd0 || bus.bout !== 1'b0 ||
            bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: out_valid=%b diff=%h bout=%b ovf=%b in_ready=%b, required 0 0 0 0 1",
                     bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.in_ready);
        end
    endtask

    task automatic test_simple();
        logic [63:0] d;
        logic bo, ov;
        int lat;
        bit ok;
        run_op(64'd5, 64'd3, 1'b0, 0, d, bo, ov, lat, ok);
        checks++;
        if (!ok || lat !== 4) begin
            errors++;
            $display("FAIL simple_latency: ok=%0d latency=%0d, required 1 and 4", ok, lat);
        end
        checks++;
        if (d !== 64'd2 || bo !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL simple_result: diff=%h bout=%b ovf=%b, required 2 0 0", d, bo, ov);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simple_release: in_ready=%b out_valid=%b, required 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [63:0] ta [5];
        logic [63:0] tb [5];
        logic        tbin [5];
        logic [63:0] td [5];
        logic        tbo [5];
        logic        tov [5];
        logic [63:0] d;
        logic bo, ov;
        int lat;
        bit ok;
        ta[0] = 64'h0000_0000_0001_0000; tb[0] = 64'd1; tbin[0] = 0;
        td[0] = 64'h0000_0000_0000_FFFF; tbo[0] = 0; tov[0] = 0;
        ta[1] = 64'd0; tb[1] = 64'd1; tbin[1] = 0;
        td[1] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[1] = 1; tov[1] = 0;
        ta[2] = 64'h8000_0000_0000_0000; tb[2] = 64'd1; tbin[2] = 0;
        td[2] = 64'h7FFF_FFFF_FFFF_FFFF; tbo[2] = 0; tov[2] = 1;
        ta[3] = 64'h1234; tb[3] = 64'h1234; tbin[3] = 1;
        td[3] = 64'hFFFF_FFFF_FFFF_FFFF; tbo[3] = 1; tov[3] = 0;
        ta[4] = 64'h7FFF_FFFF_FFFF_FFFF; tb[4] = 64'hFFFF_FFFF_FFFF_FFFF; tbin[4] = 0;
        td[4] = 64'h8000_0000_0000_0000; tbo[4] = 1; tov[4] = 1;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tbin[i], i % 2, d, bo, ov, lat, ok);
            checks++;
            if (!ok || d !== td[i] || bo !== tbo[i] || ov !== tov[i]) begin
                errors++;
                $display("FAIL directed_%0d: ok=%0d diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                         i, ok, d, bo, ov, td[i], tbo[i], tov[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ed;
        logic eb, eo;
        int n;
        model(64'd100, 64'd1, 1'b0, ed, eb, eo);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        bus.a = 64'd100; bus.b = 64'd1; bus.bin = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: out_valid=%b, required 1", bus.out_valid);
        end
        bus.a = 64'd50; bus.b = 64'd20; bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== ed ||
                bus.bout !== eb || bus.ovf !== eo) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b, required 1 0 %h %b %b",
                         c, bus.out_valid, bus.in_ready, bus.diff, bus.bout, bus.ovf, ed, eb, eo);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_consume: out_valid=%b in_ready=%b, required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4 || bus.diff !== 64'd30 || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_second: latency=%0d diff=%h bout=%b ovf=%b, required 4 1e 0 0",
                     n, bus.diff, bus.bout, bus.ovf);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic bo, ov;
        int lat;
        bit ok;
        bit seen;
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        bus.a = 64'd10; bus.b = 64'd4; bus.bin = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.diff !== 64'd0 || bus.bout !== 1'b0 ||
            bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: out_valid=%b diff=%h bout=%b ovf=%b in_ready=%b, required 0 0 0 0 1",
                     bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_result: out_valid pulse=%b, required 0", seen);
        end
        run_op(64'd10, 64'd4, 1'b0, 0, d, bo, ov, lat, ok);
        checks++;
        if (!ok || lat !== 4 || d !== 64'd6 || bo !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: ok=%0d latency=%0d diff=%h bout=%b ovf=%b, required 1 4 6 0 0",
                     ok, lat, d, bo, ov);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, d, ed;
        logic bin, bo, ov, eb, eo;
        int lat;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            a   = pick();
            b   = pick();
            bin = 1'($urandom_range(0, 1));
            model(a, b, bin, ed, eb, eo);
            run_op(a, b, bin, int'($urandom_range(0, 3)), d, bo, ov, lat, ok);
            checks++;
            if (!ok || lat !== 4 || d !== ed || bo !== eb || ov !== eo) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h bin=%b ok=%0d latency=%0d diff=%h bout=%b ovf=%b, required 4 %h %b %b",
                         i, a, b, bin, ok, lat, d, bo, ov, ed, eb, eo);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_simple();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
